// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative mult/multu/div/divu unit owning HI/LO (optional mthi/mtlo via MULDIV_MTHILO_EN)
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
`ifdef MULDIV_MTHILO_EN
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_op;
  logic r_neg_q, r_neg_r, r_dz, r_done;
  logic [WIDTH-1:0] r_a, r_div, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic w_accept, w_signed;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_quo, w_rem;
  logic [WIDTH:0] w_msum, w_shift, w_dsub;
  logic [2*WIDTH-1:0] w_mul_nx, w_div_nx, w_prod;
  assign w_accept = (r_state == IDLE) && start && !flush;
  assign w_signed = !op[0];
  // negating the most negative value wraps to itself, which is the right unsigned magnitude
  assign w_abs_a = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (w_signed && b[WIDTH-1]) ? -b : b;
  assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_acc[0] ? r_div : '0};
  assign w_mul_nx = {w_msum, r_acc[WIDTH-1:1]};
  assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_dsub = w_shift - {1'b0, r_div};
  assign w_div_nx = w_dsub[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                  : {w_dsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_accept ? RUN : IDLE;
    else if (flush) w_next = IDLE;
    else w_next = (r_state == RUN && r_cnt != '0) ? RUN : (r_state == RUN ? FIN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_op <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz <= 1'b0;
      r_done <= 1'b0;
      r_a <= '0;
      r_div <= '0;
      r_acc <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_state <= w_next;
      r_done <= (r_state == FIN) && !flush;
      if (w_accept) begin
        r_op <= op;
        r_a <= a;
        r_div <= w_abs_b;
        r_acc <= {{WIDTH{1'b0}}, w_abs_a};
        r_neg_q <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_r <= w_signed && a[WIDTH-1];
        r_dz <= op[1] && (b == '0);
        r_cnt <= CW'(WIDTH - 1);
      end else if (r_state == RUN) begin
        r_acc <= r_op[1] ? w_div_nx : w_mul_nx;
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == FIN && !flush) begin
        r_hi <= r_dz ? r_a : (r_op[1] ? w_rem : w_prod[2*WIDTH-1:WIDTH]);
        r_lo <= r_dz ? '1 : (r_op[1] ? w_quo : w_prod[WIDTH-1:0]);
      end
`ifdef MULDIV_MTHILO_EN
      else if (r_state == IDLE) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
`endif
    end
  end
  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi = r_hi;
  assign lo = r_lo;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed vectors with a done-driven scoreboard monitor
module tb_muldiv_hilo_unit;
  logic clk = 1'b0;
  logic rst, start, flush;
  logic [1:0] op;
  logic [31:0] a, b;
  logic busy, done;
  logic [31:0] hi, lo;
  logic [63:0] sb[$];
  logic [63:0] exp_v;
  int n_checks = 0;
  int n_pass = 0;
  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 expected no done (hi=%h lo=%h)", hi, lo);
      end else begin
        exp_v = sb.pop_front();
        check("result_hi", hi, exp_v[63:32]);
        check("result_lo", lo, exp_v[31:0]);
      end
    end
  end
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int poke, input int fl, input int rc);
    int cyc;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    if (fl < 0 && rc < 0) sb.push_back({eh, el});
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && done !== 1'b1 && cyc < 100) begin
      cyc++;
      start = (cyc == poke);
      if (cyc == poke) begin op = 2'b00; a = 32'd7; b = 32'd7; end
      flush = (cyc == fl);
      rst = (cyc == rc);
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0; rst = 1'b0;
    if (fl > 0 || rc > 0) begin
      check("abort_cycle", 32'(cyc), 32'(fl > 0 ? fl : rc));
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_hi", hi, eh);
      check("abort_lo", lo, el);
    end else begin
      check("busy_cycles", 32'(cyc), 32'd33);
      check("done_pulse", 32'(done), 32'd1);
      @(posedge clk); #1;
      check("done_drops", 32'(done), 32'd0);
      if (poke > 0) begin
        @(posedge clk); #1;
        check("start_not_queued", 32'(busy), 32'd0);
      end
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, -1, -1, -1);
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, -1, -1, -1);
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, -1, -1, -1);
    run_op(2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, -1, -1, -1);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, -1, -1, -1);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, -1, -1, -1);
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, -1, -1, -1);
    run_op(2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, -1, -1, -1);
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, -1, -1, -1);
    run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 5, -1, -1);
    run_op(2'b01, 32'd9, 32'd9, 32'd0, 32'd81, 33, -1, -1);
    run_op(2'b01, 32'd5, 32'd1, 32'd0, 32'd5, -1, -1, -1);
    run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd5, -1, 10, -1);
    run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd0, -1, -1, 12);
    @(posedge clk); #1;
    op = 2'b01; a = 32'd6; b = 32'd6; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush_beats_start", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("idle_flush_lo_kept", lo, 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
